gin_mc_buffered: RTL and testbench

Parametrised, buffered multicast receiver for one PE port on the Global Input Network (GIN). It holds a programmable ID and match mask and decodes the bus tag in exact, masked or broadcast mode. Matching bus transfers are captured into a DEPTH-entry FIFO, which decouples PE back-pressure from the bus. It sits between the GIN X/Y bus and a PE (or a lower-level row controller) and supersedes the purely combinational tag/ID gate.

---
 rtl/gin_mc_buffered.sv | 176 +++++++++++++++++
 tb/tb_gin_mc_buffered.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gin_mc_buffered.sv
// gin_mc_buffered
// ---------------
// Buffered multicast receiver for one PE port on the Global Input Network.
// A programmable ID and match mask select which bus tags this port takes.
// Tags can match exactly, under a mask, or as an all-ones broadcast.
// Accepted bus transfers are written into a small FIFO, so PE back-pressure
// never reaches the bus directly.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid and ready are both high.
//   - Bus side: bus_valid comes from the bus and bus_ready from this port.
//     bus_ready is low whenever the tag does not match, so the bus can AND
//     the ready signals of the matching ports only.
//   - PE side: pe_valid comes from this port and pe_ready from the PE.
//     pe_valid and pe_data come from registers only.
//
// Parameters:
//   ID_SIZE   - width of id, mask and tag
//   DATA_SIZE - payload width
//   DEPTH     - FIFO entries (power of two, >= 2)
//   CNT_SIZE  - width of the saturating accepted-transfer counter
//
// Ports:
//   clk, rst             - clock (rising edge), asynchronous active-high reset
//   set_id, id_in        - load a new ID on the next edge
//   set_mask, mask_in    - load a new mask on the next edge (1 = bit compared)
//   bcast_en             - accept the all-ones tag as a broadcast
//   flush                - synchronous clear of the FIFO contents
//   id                   - current ID register
//   tag, bus_valid,
//   bus_data, bus_ready  - GIN bus side
//   pe_valid, pe_data,
//   pe_ready             - PE side (FIFO head)
//   hit                  - combinational tag match, ignores FIFO space
//   acc_cnt              - saturating count of accepted transfers

`ifndef XID_BITS
`define XID_BITS 5
`endif

module gin_mc_buffered #(
    parameter int ID_SIZE   = `XID_BITS,
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 2,
    parameter int CNT_SIZE  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_id,
    input  logic [ID_SIZE-1:0]   id_in,
    input  logic                 set_mask,
    input  logic [ID_SIZE-1:0]   mask_in,
    input  logic                 bcast_en,
    input  logic                 flush,
    output logic [ID_SIZE-1:0]   id,
    input  logic [ID_SIZE-1:0]   tag,
    input  logic                 bus_valid,
    input  logic [DATA_SIZE-1:0] bus_data,
    output logic                 bus_ready,
    output logic                 pe_valid,
    output logic [DATA_SIZE-1:0] pe_data,
    input  logic                 pe_ready,
    output logic                 hit,
    output logic [CNT_SIZE-1:0]  acc_cnt
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [ID_SIZE-1:0]  ID_ONES  = {ID_SIZE{1'b1}};
    localparam logic [CNT_SIZE-1:0] CNT_MAX  = {CNT_SIZE{1'b1}};
    localparam logic [CNT_SIZE-1:0] CNT_ONE  = {{(CNT_SIZE-1){1'b0}}, 1'b1};
    localparam logic [AW:0]         PTR_ONE  = {{AW{1'b0}}, 1'b1};

    logic [ID_SIZE-1:0]   mask;
    logic [DATA_SIZE-1:0] mem [DEPTH];

    // One extra pointer bit tells full apart from empty. The pointers wrap
    // naturally modulo 2*DEPTH.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // ------------------------------------------------------------------
    // Tag decode
    // ------------------------------------------------------------------
    always_comb begin
        hit = ((tag & mask) == (id & mask)) | (bcast_en & (tag == ID_ONES));
    end

    // ------------------------------------------------------------------
    // FIFO status and handshakes
    // ------------------------------------------------------------------
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    end

    // Full blocks the bus even when the PE pops in the same cycle. There is
    // no pass-through, which keeps bus_ready free of any path from pe_ready.
    assign bus_ready = hit & ~full & ~flush;
    assign pe_valid  = ~empty;
    assign pe_data   = mem[rd_ptr[AW-1:0]];

    // A flush discards any pop in the same cycle. Push is already blocked
    // through bus_ready.
    assign push = bus_valid & bus_ready;
    assign pop  = pe_valid & pe_ready & ~flush;

    // ------------------------------------------------------------------
    // ID and mask registers. A transfer in the same cycle as a set_* is
    // decided with the old values, because the new value only appears
    // after the edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id   <= '0;
            mask <= ID_ONES;
        end else begin
            if (set_id) begin
                id <= id_in;
            end
            if (set_mask) begin
                mask <= mask_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage. Reset clears it so that pe_data reads zero after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus_data;
        end
    end

    // ------------------------------------------------------------------
    // Accepted-transfer counter. It saturates and survives a flush.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt <= '0;
        end else if (push && (acc_cnt != CNT_MAX)) begin
            acc_cnt <= acc_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_gin_mc_buffered.sv
// Testbench for gin_mc_buffered.
// Main DUT: ID_SIZE=5, DATA_SIZE=32, DEPTH=2, CNT_SIZE=16.
// Second DUT: CNT_SIZE=4, used for the counter saturation and reset-abort case.

module tb_gin_mc_buffered;

    localparam int ID_SIZE   = 5;
    localparam int DATA_SIZE = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT signals ----------------
    logic                 set_id = 0, set_mask = 0, bcast_en = 0, flush = 0;
    logic [ID_SIZE-1:0]   id_in = '0, mask_in = '0, tag = '0;
    logic                 bus_valid = 0, pe_ready = 0;
    logic [DATA_SIZE-1:0] bus_data = '0;
    logic [ID_SIZE-1:0]   id;
    logic                 bus_ready, pe_valid, hit;
    logic [DATA_SIZE-1:0] pe_data;
    logic [15:0]          acc_cnt;

    gin_mc_buffered #(.ID_SIZE(ID_SIZE), .DATA_SIZE(DATA_SIZE), .DEPTH(2), .CNT_SIZE(16)) u_dut (
        .clk(clk), .rst(rst), .set_id(set_id), .id_in(id_in), .set_mask(set_mask),
        .mask_in(mask_in), .bcast_en(bcast_en), .flush(flush), .id(id), .tag(tag),
        .bus_valid(bus_valid), .bus_data(bus_data), .bus_ready(bus_ready),
        .pe_valid(pe_valid), .pe_data(pe_data), .pe_ready(pe_ready), .hit(hit),
        .acc_cnt(acc_cnt)
    );

    // ---------------- saturation DUT signals ----------------
    logic                 rst2 = 1'b1;
    logic                 set_id2 = 0, bus_valid2 = 0, pe_ready2 = 0;
    logic [ID_SIZE-1:0]   id_in2 = '0, tag2 = '0;
    logic [DATA_SIZE-1:0] bus_data2 = '0;
    logic [ID_SIZE-1:0]   id2;
    logic                 bus_ready2, pe_valid2, hit2;
    logic [DATA_SIZE-1:0] pe_data2;
    logic [3:0]           acc_cnt2;

    gin_mc_buffered #(.ID_SIZE(ID_SIZE), .DATA_SIZE(DATA_SIZE), .DEPTH(2), .CNT_SIZE(4)) u_sat (
        .clk(clk), .rst(rst2), .set_id(set_id2), .id_in(id_in2), .set_mask(1'b0),
        .mask_in('0), .bcast_en(1'b0), .flush(1'b0), .id(id2), .tag(tag2),
        .bus_valid(bus_valid2), .bus_data(bus_data2), .bus_ready(bus_ready2),
        .pe_valid(pe_valid2), .pe_data(pe_data2), .pe_ready(pe_ready2), .hit(hit2),
        .acc_cnt(acc_cnt2)
    );

    // ---------------- scoreboard ----------------
    logic [DATA_SIZE-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // The monitor compares every PE-side pop against the queue head.
    always @(negedge clk) begin
        if (!rst && pe_valid && pe_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pe_pop: got 0x%0h, expected no pop (queue empty)", pe_data);
            end else begin
                check("pe_pop", pe_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one bus beat, checks bus_ready, and queues the data if the
    // beat is expected to be accepted.
    task automatic bus_beat(input string name, input logic [ID_SIZE-1:0] t,
                            input logic [DATA_SIZE-1:0] d, input logic exp_ready);
        tag       = t;
        bus_data  = d;
        bus_valid = 1'b1;
        #1;
        check(name, {31'b0, bus_ready}, {31'b0, exp_ready});
        if (exp_ready) exp_q.push_back(d);
        tick();
        bus_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        tick();
        tag = 5'd0;
        #1;
        check("rst_id", {27'b0, id}, 32'd0);
        check("rst_pe_valid", {31'b0, pe_valid}, 32'd0);
        check("rst_pe_data", pe_data, 32'd0);
        check("rst_acc_cnt", {16'b0, acc_cnt}, 32'd0);
        check("rst_ready_tag0", {31'b0, bus_ready}, 32'd1);
        tag = 5'd3;
        #1;
        check("rst_ready_tag3", {31'b0, bus_ready}, 32'd0);
        tick();
        rst  = 1'b0;
        rst2 = 1'b0;

        // Exact match, id = 5
        set_id = 1'b1; id_in = 5'd5;
        tick();
        set_id = 1'b0;
        check("id_loaded", {27'b0, id}, 32'd5);
        bus_beat("exact_ready", 5'd5, 32'hA5, 1'b1);
        check("exact_pe_valid", {31'b0, pe_valid}, 32'd1);
        check("exact_acc", {16'b0, acc_cnt}, 32'd1);
        pe_ready = 1'b1;
        tick();
        pe_ready = 1'b0;
        tag = 5'd6;
        #1;
        check("miss_hit", {31'b0, hit}, 32'd0);
        bus_beat("miss_ready", 5'd6, 32'hBB, 1'b0);
        check("miss_acc", {16'b0, acc_cnt}, 32'd1);
        check("miss_pe_valid", {31'b0, pe_valid}, 32'd0);

        // Masked match and broadcast
        set_mask = 1'b1; mask_in = 5'b11100;
        set_id = 1'b1; id_in = 5'b01000;
        tick();
        set_mask = 1'b0; set_id = 1'b0;
        tag = 5'b01011; #1; check("mask_hit_01011", {31'b0, hit}, 32'd1);
        tag = 5'b01100; #1; check("mask_hit_01100", {31'b0, hit}, 32'd0);
        bcast_en = 1'b1; tag = 5'b11111; #1; check("bcast_on", {31'b0, hit}, 32'd1);
        bcast_en = 1'b0; #1; check("bcast_off", {31'b0, hit}, 32'd0);

        // Full FIFO with mask 0, which matches every tag
        set_mask = 1'b1; mask_in = 5'b00000;
        tick();
        set_mask = 1'b0;
        bus_beat("fill_0", 5'd9, 32'h11, 1'b1);
        bus_beat("fill_1", 5'd9, 32'h22, 1'b1);
        tag = 5'd9; bus_data = 32'h33; bus_valid = 1'b1; pe_ready = 1'b1;
        #1;
        check("full_ready", {31'b0, bus_ready}, 32'd0);
        check("full_hit", {31'b0, hit}, 32'd1);
        tick();
        bus_valid = 1'b0;
        #1;
        check("after_pop_ready", {31'b0, bus_ready}, 32'd1);
        tick();
        check("drained", {31'b0, pe_valid}, 32'd0);
        pe_ready = 1'b0;

        // Streaming after a reset: 1..8 with pe_ready high
        do_reset();
        pe_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) check("stream_valid", {31'b0, pe_valid}, 32'd1);
            bus_beat("stream_ready", 5'd0, i, 1'b1);
        end
        tick();
        check("stream_acc", {16'b0, acc_cnt}, 32'd8);
        check("stream_empty", {31'b0, pe_valid}, 32'd0);
        pe_ready = 1'b0;

        // Flush with two entries buffered
        bus_beat("pre_flush_0", 5'd0, 32'h44, 1'b1);
        bus_beat("pre_flush_1", 5'd0, 32'h55, 1'b1);
        flush = 1'b1; bus_valid = 1'b1; bus_data = 32'h66;
        #1;
        check("flush_ready", {31'b0, bus_ready}, 32'd0);
        tick();
        flush = 1'b0; bus_valid = 1'b0;
        exp_q.delete();
        check("flush_pe_valid", {31'b0, pe_valid}, 32'd0);
        check("flush_acc", {16'b0, acc_cnt}, 32'd10);

        // Saturation on the 4-bit counter instance, then a mid-stream reset
        set_id2 = 1'b1; id_in2 = 5'd3;
        tick();
        set_id2 = 1'b0;
        tag2 = 5'd3; pe_ready2 = 1'b1; bus_valid2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus_data2 = i;
            tick();
        end
        check("sat_acc", {28'b0, acc_cnt2}, 32'd15);
        check("sat_id", {27'b0, id2}, 32'd3);
        pe_ready2 = 1'b0;
        tick();
        check("sat_pe_valid", {31'b0, pe_valid2}, 32'd1);
        rst2 = 1'b1;
        #1;
        check("arst_acc", {28'b0, acc_cnt2}, 32'd0);
        check("arst_pe_valid", {31'b0, pe_valid2}, 32'd0);
        check("arst_id", {27'b0, id2}, 32'd0);
        bus_valid2 = 1'b0;
        tick();
        rst2 = 1'b0;

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
